// File: rtl/amo_q_pkg.sv
// rtl/amo_q_pkg.sv - shared types, widths and sign-adjust helper for the AMO issue queue
package amo_q_pkg;

    localparam int unsigned PLEN      = 56;
    localparam int unsigned SIZE_DATA = 64;
    localparam int unsigned TAG_W_MAX = 16;

    typedef enum logic [3:0] {
        AMO_NONE, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
        AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU, AMO_CAS1, AMO_CAS2
    } amo_t;

    typedef struct packed {
        logic        req;
        amo_t        amo_op;
        logic [1:0]  size;
        logic [63:0] operand_a;
        logic [63:0] operand_b;
    } amo_req_t;

    typedef struct packed {
        logic        ack;
        logic [63:0] result;
    } amo_resp_t;

    typedef struct packed {
        amo_t                 op;
        logic [PLEN-1:0]      paddr;
        logic [SIZE_DATA-1:0] data;
        logic [1:0]           size;
        logic [TAG_W_MAX-1:0] tag;
    } amo_entry_t;

    typedef enum logic [1:0] {IDLE, DRAIN, ISSUE, DONE} amo_state_e;

    // Word-sized AMOs carry a 32-bit value that must be sign-extended to XLEN.
    function automatic logic [63:0] sext_word(input logic [63:0] v, input logic [1:0] size);
        return (size == 2'b10) ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

endpackage

// File: rtl/amo_q_fifo.sv
// rtl/amo_q_fifo.sv - generic circular-buffer storage with count, full/empty and head-preserving flush
module amo_q_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic             keep_head_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    // A flush keeps the head only when it is the op currently in flight at the cache.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            if (keep_head_i && !pop_i && cnt_q != '0) begin
                wr_q  <= next_ptr(rd_q);
                cnt_q <= CNT_W'(1);
            end else begin
                rd_q  <= pop_i ? next_ptr(rd_q) : rd_q;
                wr_q  <= pop_i ? next_ptr(rd_q) : rd_q;
                cnt_q <= '0;
            end
        end else begin
            if (push_i) wr_q <= next_ptr(wr_q);
            if (pop_i)  rd_q <= next_ptr(rd_q);
            if (push_i && !pop_i)      cnt_q <= cnt_q + CNT_W'(1);
            else if (pop_i && !push_i) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/amo_issue_queue.sv
// rtl/amo_issue_queue.sv - in-order AMO queue issuing one op at a time to the D-cache
// Optional watchdog on the ISSUE state is built when AMO_WATCHDOG_EN is defined.
module amo_issue_queue
    import amo_q_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TAG_W       = 7,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  amo_t                 amo_op_i,
    input  logic [SIZE_DATA-1:0] data_i,
    input  logic [PLEN-1:0]      paddr_i,
    input  logic [1:0]           size_i,
    input  logic [TAG_W-1:0]     tag_i,
    input  logic                 flush_i,
    input  logic                 no_mem_ops_pending_i,
    output amo_req_t             amo_req_o,
    input  amo_resp_t            amo_resp_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [63:0]          result_o,
    output logic [TAG_W-1:0]     result_tag_o,
    output logic                 busy_o,
    output logic                 error_o
);
    amo_state_e       state_q, state_d;
    logic             drop_q, drop_d;
    logic [63:0]      result_q, result_d;
    logic [TAG_W-1:0] result_tag_q, result_tag_d;

    amo_entry_t entry_in, head;
    logic       push, pop, full, empty;

    always_comb begin
        entry_in              = '0;
        entry_in.op           = amo_op_i;
        entry_in.paddr        = paddr_i;
        entry_in.data         = data_i;
        entry_in.size         = size_i;
        entry_in.tag[TAG_W-1:0] = tag_i;
    end

    // A pop frees a slot in the same cycle, so a full queue can still accept.
    assign ready_o = !full || pop;
    assign push    = valid_i && ready_o && !flush_i;

    amo_q_fifo #(
        .WIDTH ($bits(amo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .data_i      (entry_in),
        .pop_i       (pop),
        .flush_i     (flush_i),
        .keep_head_i (state_q == ISSUE),
        .data_o      (head),
        .full_o      (full),
        .empty_o     (empty)
    );

    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        result_d     = result_q;
        result_tag_d = result_tag_q;
        pop          = 1'b0;
        case (state_q)
            IDLE:  if (!empty && !flush_i) state_d = DRAIN;
            DRAIN: begin
                if (flush_i)                   state_d = IDLE;
                else if (no_mem_ops_pending_i) state_d = ISSUE;
            end
            ISSUE: begin
                if (flush_i) drop_d = 1'b1;
                if (amo_resp_i.ack) begin
                    pop    = 1'b1;
                    drop_d = 1'b0;
                    // A flushed in-flight op still completes at the cache; only its result is discarded.
                    if (drop_q || flush_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = DONE;
                        result_d     = sext_word(amo_resp_i.result, head.size);
                        result_tag_d = head.tag[TAG_W-1:0];
                    end
                end
            end
            DONE: if (result_ready_i) state_d = (empty || flush_i) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            drop_q       <= 1'b0;
            result_q     <= '0;
            result_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            drop_q       <= drop_d;
            result_q     <= result_d;
            result_tag_q <= result_tag_d;
        end
    end

    always_comb begin
        amo_req_o = '0;
        if (state_q == ISSUE) begin
            amo_req_o.req       = 1'b1;
            amo_req_o.amo_op    = head.op;
            amo_req_o.size      = head.size;
            amo_req_o.operand_a = {{(64-PLEN){1'b0}}, head.paddr};
            amo_req_o.operand_b = sext_word(head.data, head.size);
        end
    end

    assign result_valid_o = (state_q == DONE);
    assign result_o       = result_q;
    assign result_tag_o   = result_tag_q;
    assign busy_o         = !empty || (state_q != IDLE);

`ifdef AMO_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q != ISSUE)                wd_q <= '0;
            else if (wd_q != WD_W'(TIMEOUT_CYC)) wd_q <= wd_q + WD_W'(1);
            if (wd_q == WD_W'(TIMEOUT_CYC))      err_q <= 1'b1;
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_amo_issue_queue.sv
// tb/tb_amo_issue_queue.sv - directed self-checking bench for amo_issue_queue
module tb_amo_issue_queue;
    import amo_q_pkg::*;

    localparam int TAG_W   = 7;
    localparam int TIMEOUT = 1024;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_i, ready_o, flush_i, nmp_i;
    amo_t             amo_op_i;
    logic [63:0]      data_i;
    logic [PLEN-1:0]  paddr_i;
    logic [1:0]       size_i;
    logic [TAG_W-1:0] tag_i;
    amo_req_t         amo_req;
    amo_resp_t        amo_resp;
    logic             result_valid, result_ready;
    logic [63:0]      result;
    logic [TAG_W-1:0] result_tag;
    logic             busy, error;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    amo_issue_queue #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .valid_i              (valid_i),
        .ready_o              (ready_o),
        .amo_op_i             (amo_op_i),
        .data_i               (data_i),
        .paddr_i              (paddr_i),
        .size_i               (size_i),
        .tag_i                (tag_i),
        .flush_i              (flush_i),
        .no_mem_ops_pending_i (nmp_i),
        .amo_req_o            (amo_req),
        .amo_resp_i           (amo_resp),
        .result_valid_o       (result_valid),
        .result_ready_i       (result_ready),
        .result_o             (result),
        .result_tag_o         (result_tag),
        .busy_o               (busy),
        .error_o              (error)
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] d2(input int i);
        return 64'h0123_4567_89AB_CDEF ^ (64'(i) << 40);
    endfunction

    task automatic push(input amo_t op, input logic [1:0] sz, input logic [63:0] d, input logic [TAG_W-1:0] t);
        valid_i  = 1'b1;
        amo_op_i = op;
        size_i   = sz;
        data_i   = d;
        tag_i    = t;
        paddr_i  = PLEN'({t, 3'b000});
        @(negedge clk);
        valid_i  = 1'b0;
    endtask

    task automatic wait_req(input string name, output int cyc);
        cyc = 0;
        while (!amo_req.req && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({name, "_req_seen"}, 64'(amo_req.req), 64'd1);
    endtask

    task automatic ack_with(input logic [63:0] r);
        amo_resp.ack    = 1'b1;
        amo_resp.result = r;
        @(negedge clk);
        amo_resp.ack    = 1'b0;
    endtask

    task automatic take_result(input string name, input logic [63:0] r, input logic [TAG_W-1:0] t);
        int c = 0;
        while (!result_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        check_eq({name, "_valid"}, 64'(result_valid), 64'd1);
        check_eq({name, "_result"}, result, r);
        check_eq({name, "_tag"}, 64'(result_tag), 64'(t));
        check_eq({name, "_no_req"}, 64'(amo_req.req), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        int hits;
        int hits2;
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; nmp_i = 1'b1; result_ready = 1'b1;
        amo_op_i = AMO_NONE; data_i = '0; paddr_i = '0; size_i = 2'b11; tag_i = '0;
        amo_resp = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 64'(ready_o), 64'd1);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_req", 64'(amo_req.req), 64'd0);
        check_eq("rst_rvalid", 64'(result_valid), 64'd0);
        check_eq("rst_error", 64'(error), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // single word AMOADD: operand and result sign extension, 3-cycle latency
        push(AMO_ADD, 2'b10, 64'h0000_0000_FFFF_FFFF, 7'd5);
        wait_req("t1", cyc);
        check_eq("t1_latency", 64'(cyc), 64'd2);
        check_eq("t1_opb", amo_req.operand_b, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("t1_opa", amo_req.operand_a, 64'h28);
        check_eq("t1_op", 64'(amo_req.amo_op), 64'(AMO_ADD));
        check_eq("t1_size", 64'(amo_req.size), 64'd2);
        @(negedge clk);
        check_eq("t1_req_hold", 64'(amo_req.req), 64'd1);
        ack_with(64'h0000_0000_8000_0000);
        take_result("t1", 64'hFFFF_FFFF_8000_0000, 7'd5);
        check_eq("t1_idle", 64'(busy), 64'd0);

        // fill to DEPTH, push while full and popping, drain in order
        for (int i = 0; i < 4; i++) push(AMO_SWAP, 2'b11, d2(i), 7'(10 + i));
        check_eq("t2_full", 64'(ready_o), 64'd0);
        wait_req("t2_0", cyc);
        check_eq("t2_0_opb", amo_req.operand_b, d2(0));
        amo_resp.ack = 1'b1; amo_resp.result = ~d2(0);
        valid_i = 1'b1; amo_op_i = AMO_SWAP; size_i = 2'b11; data_i = d2(4); tag_i = 7'd14;
        #1;
        check_eq("t2_ready_on_pop", 64'(ready_o), 64'd1);
        @(negedge clk);
        amo_resp.ack = 1'b0; valid_i = 1'b0;
        check_eq("t2_still_full", 64'(ready_o), 64'd0);
        take_result("t2_0", ~d2(0), 7'd10);
        for (int i = 1; i < 5; i++) begin
            wait_req("t2_n", cyc);
            check_eq("t2_n_opb", amo_req.operand_b, d2(i));
            ack_with(~d2(i));
            take_result("t2_n", ~d2(i), 7'(10 + i));
        end
        check_eq("t2_idle", 64'(busy), 64'd0);

        // LSQ not drained holds issue
        nmp_i = 1'b0;
        push(AMO_OR, 2'b11, 64'h55, 7'd20);
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (amo_req.req) hits++;
        end
        check_eq("t3_no_req", 64'(hits), 64'd0);
        nmp_i = 1'b1;
        @(negedge clk);
        check_eq("t3_req_rise", 64'(amo_req.req), 64'd1);
        ack_with(64'h42);
        take_result("t3", 64'h42, 7'd20);

        // flush during ISSUE: op completes, result dropped, queue empties
        for (int i = 0; i < 3; i++) push(AMO_XOR, 2'b10, 64'(i + 1), 7'(30 + i));
        wait_req("t4", cyc);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check_eq("t4_inflight", 64'(amo_req.req), 64'd1);
        check_eq("t4_opb_stable", amo_req.operand_b, 64'd1);
        ack_with(64'hFFFF_FFFF_FFFF_FFFF);
        hits = 0; hits2 = 0;
        repeat (6) begin
            if (result_valid) hits++;
            if (amo_req.req) hits2++;
            @(negedge clk);
        end
        check_eq("t4_no_result", 64'(hits), 64'd0);
        check_eq("t4_no_req", 64'(hits2), 64'd0);
        check_eq("t4_busy", 64'(busy), 64'd0);
        check_eq("t4_ready", 64'(ready_o), 64'd1);

        // writeback backpressure holds result, blocks next issue
        push(AMO_AND, 2'b10, 64'h0, 7'd40);
        push(AMO_MAX, 2'b11, 64'h9, 7'd41);
        result_ready = 1'b0;
        wait_req("t5", cyc);
        ack_with(64'h7FFF_FFFF_1234_5678);
        check_eq("t5_valid", 64'(result_valid), 64'd1);
        check_eq("t5_result", result, 64'h0000_0000_1234_5678);
        check_eq("t5_tag", 64'(result_tag), 64'd40);
        hits = 0;
        repeat (5) begin
            @(negedge clk);
            if (result !== 64'h0000_0000_1234_5678 || result_tag !== 7'd40 || !result_valid || amo_req.req)
                hits++;
        end
        check_eq("t5_hold", 64'(hits), 64'd0);
        result_ready = 1'b1;
        @(negedge clk);
        wait_req("t5b", cyc);
        check_eq("t5b_opb", amo_req.operand_b, 64'h9);
        ack_with(64'h8000_0000_0000_0000);
        take_result("t5b", 64'h8000_0000_0000_0000, 7'd41);

        // push coinciding with flush is dropped
        valid_i = 1'b1; flush_i = 1'b1; tag_i = 7'd45;
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        check_eq("t6_dropped_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check_eq("t6_dropped_req", 64'(amo_req.req), 64'd0);

`ifdef AMO_WATCHDOG_EN
        push(AMO_MINU, 2'b11, 64'h3, 7'd55);
        wait_req("t7w", cyc);
        repeat (TIMEOUT + 4) @(negedge clk);
        check_eq("t7_error", 64'(error), 64'd1);
        check_eq("t7_req_held", 64'(amo_req.req), 64'd1);
`else
        check_eq("t7_error_off", 64'(error), 64'd0);
`endif

        // async reset mid-ISSUE
        if (!amo_req.req) begin
            push(AMO_MIN, 2'b11, 64'h1, 7'd50);
            wait_req("t8", cyc);
        end
        #2 rst = 1'b1;
        #1;
        check_eq("t8_req", 64'(amo_req.req), 64'd0);
        check_eq("t8_ready", 64'(ready_o), 64'd1);
        check_eq("t8_busy", 64'(busy), 64'd0);
        check_eq("t8_error", 64'(error), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t8_after_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
